// File: rtl/ram_port_arbiter.sv
// Arbitrates the single block-RAM data port between the CPU (priority) and the debug port.
// States: IDLE = arbitrate | ISSUE = RAM samples request | CAPTURE = RAM data valid | ACK = ack pulse.
module ram_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              qzt_clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              owner,
  output logic              busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_ACK     = 2'd3;
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  logic [1:0]        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              op_we_q, op_we_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              cpu_wins;

  assign cpu_wins = cpu_req && (!dbg_req || (starve_q < LIMIT));

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    op_we_d     = op_we_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    cpu_ack_d   = cpu_ack_q;
    dbg_ack_d   = dbg_ack_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_wins) begin
          state_d     = S_ISSUE;
          op_we_d     = cpu_we;
          ram_en_d    = 1'b1;
          ram_we_d    = cpu_we;
          ram_addr_d  = cpu_addr;
          ram_wdata_d = cpu_wdata;
          owner_d     = 1'b0;
          busy_d      = 1'b1;
          // Only CPU grants that bypass a waiting debug request count toward starvation.
          if (!dbg_req)
            starve_d = 4'd0;
          else if (starve_q < LIMIT)
            starve_d = starve_q + 4'd1;
        end else if (dbg_req) begin
          state_d     = S_ISSUE;
          op_we_d     = dbg_we;
          ram_en_d    = 1'b1;
          ram_we_d    = dbg_we;
          ram_addr_d  = dbg_addr;
          ram_wdata_d = dbg_wdata;
          owner_d     = 1'b1;
          busy_d      = 1'b1;
          starve_d    = 4'd0;
        end
      end
      S_ISSUE: begin
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
        state_d  = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (owner_q) begin
          if (!op_we_q) dbg_rdata_d = ram_rdata;
          dbg_ack_d = 1'b1;
        end else begin
          if (!op_we_q) cpu_rdata_d = ram_rdata;
          cpu_ack_d = 1'b1;
        end
        state_d = S_ACK;
      end
      default: begin
        cpu_ack_d = 1'b0;
        dbg_ack_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      starve_q    <= 4'd0;
      op_we_q     <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      op_we_q     <= op_we_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboarded bench for ram_port_arbiter with a behavioural 256-byte synchronous RAM.
module tb_ram_port_arbiter;

  logic       qzt_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0;
  logic       dbg_req = 1'b0, dbg_we = 1'b0;
  logic [7:0] dbg_addr = '0, dbg_wdata = '0;
  logic       cpu_ack, dbg_ack, ram_en, ram_we, owner, busy;
  logic [7:0] cpu_rdata, dbg_rdata, ram_addr, ram_wdata;
  logic [7:0] ram_rdata = '0;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_cpu_rd, exp_dbg_rd;

  typedef struct {
    bit         port;
    logic [7:0] rdata;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 qzt_clk = ~qzt_clk;

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(4)) dut (
    .qzt_clk(qzt_clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .owner(owner), .busy(busy)
  );

  always @(posedge qzt_clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic pop_ack(input bit port, input logic [7:0] rdata);
    exp_t e;
    if (sb.size() == 0) begin
      check(port ? "unexpected_dbg_ack" : "unexpected_cpu_ack", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("ack_port", {31'd0, port}, {31'd0, e.port});
      check(port ? "dbg_rdata" : "cpu_rdata", {24'd0, rdata}, {24'd0, e.rdata});
    end
  endtask

  always @(negedge qzt_clk) begin
    if (!reset) begin
      if (cpu_ack) pop_ack(1'b0, cpu_rdata);
      if (dbg_ack) pop_ack(1'b1, dbg_rdata);
    end
  end

  task automatic expect_access(input bit port, input bit we, input logic [7:0] addr,
                               input logic [7:0] wdata);
    exp_t e;
    e.port = port;
    if (we) begin
      ref_mem[addr] = wdata;
      e.rdata = port ? exp_dbg_rd : exp_cpu_rd;
    end else begin
      e.rdata = ref_mem[addr];
      if (port) exp_dbg_rd = ref_mem[addr];
      else      exp_cpu_rd = ref_mem[addr];
    end
    sb.push_back(e);
  endtask

  // Uncontested access: drives at a negedge, checks grant-cycle outputs and ack latency.
  task automatic access(input bit port, input bit we, input logic [7:0] addr,
                        input logic [7:0] wdata);
    int lat = 0;
    if (port) begin dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1; end
    else      begin cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1; end
    expect_access(port, we, addr, wdata);
    for (int i = 1; i <= 40; i++) begin
      @(negedge qzt_clk);
      if (i == 1) begin
        check("grant_ram_en", {31'd0, ram_en}, 32'd1);
        check("grant_ram_we", {31'd0, ram_we}, {31'd0, we});
        check("grant_ram_addr", {24'd0, ram_addr}, {24'd0, addr});
        check("grant_owner", {31'd0, owner}, {31'd0, port});
        check("grant_busy", {31'd0, busy}, 32'd1);
        if (we) check("grant_ram_wdata", {24'd0, ram_wdata}, {24'd0, wdata});
      end
      if (i == 2) check("issue_done_ram_en", {31'd0, ram_en}, 32'd0);
      if (port ? dbg_ack : cpu_ack) begin lat = i; break; end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    check("ack_latency", lat, 3);
    @(negedge qzt_clk);
    check("ack_single_cycle", {31'd0, port ? dbg_ack : cpu_ack}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int tc, td, ncpu;
    bit dbg_done, resumed;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    mem[8'h3C] = 8'hA5; ref_mem[8'h3C] = 8'hA5;
    exp_cpu_rd = 8'h00;
    exp_dbg_rd = 8'h00;

    repeat (3) @(negedge qzt_clk);
    reset = 1'b0;
    @(negedge qzt_clk);
    check("rst_outputs", {cpu_ack, dbg_ack, ram_en, ram_we, owner, busy, ram_addr, ram_wdata,
                          cpu_rdata, dbg_rdata}, 38'd0);

    access(1'b0, 1'b0, 8'h3C, 8'h00);
    access(1'b1, 1'b1, 8'h10, 8'h5A);
    check("cpu_rdata_hold", {24'd0, cpu_rdata}, 32'hA5);
    access(1'b0, 1'b0, 8'h10, 8'h00);
    access(1'b1, 1'b0, 8'h3C, 8'h00);

    // Simultaneous requests: CPU first, debug exactly 4 cycles later.
    cpu_we = 1'b0; cpu_addr = 8'h3C; dbg_we = 1'b0; dbg_addr = 8'h10;
    cpu_req = 1'b1; dbg_req = 1'b1;
    expect_access(1'b0, 1'b0, 8'h3C, 8'h00);
    expect_access(1'b1, 1'b0, 8'h10, 8'h00);
    tc = 0; td = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge qzt_clk);
      if (cpu_ack) begin tc = i; cpu_req = 1'b0; end
      if (dbg_ack) begin td = i; dbg_req = 1'b0; break; end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("sim_cpu_ack_time", tc, 3);
    check("sim_dbg_ack_time", td, 7);

    // Starvation: continuous CPU traffic with debug pending.
    @(negedge qzt_clk);
    cpu_we = 1'b0; cpu_addr = 8'h21; dbg_we = 1'b0; dbg_addr = 8'h22;
    cpu_req = 1'b1; dbg_req = 1'b1;
    for (int k = 0; k < 4; k++) expect_access(1'b0, 1'b0, 8'h21, 8'h00);
    expect_access(1'b1, 1'b0, 8'h22, 8'h00);
    expect_access(1'b0, 1'b0, 8'h21, 8'h00);
    ncpu = 0; dbg_done = 0; resumed = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge qzt_clk);
      if (cpu_ack) begin
        if (dbg_done) begin resumed = 1; cpu_req = 1'b0; break; end
        ncpu++;
      end
      if (dbg_ack) begin
        dbg_done = 1;
        dbg_req  = 1'b0;
        check("starve_cleared", {28'd0, dut.starve_q}, 32'd0);
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("starve_cpu_acks", ncpu, 4);
    check("starve_dbg_served", {31'd0, dbg_done}, 32'd1);
    check("starve_cpu_resumed", {31'd0, resumed}, 32'd1);
    @(negedge qzt_clk);

    // Reset asserted during CAPTURE of a CPU read: no ack, outputs cleared at once.
    cpu_we = 1'b0; cpu_addr = 8'h3C; cpu_req = 1'b1;
    @(negedge qzt_clk);
    @(negedge qzt_clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_outputs", {cpu_ack, dbg_ack, ram_en, ram_we, owner, busy, ram_addr, ram_wdata,
                             cpu_rdata, dbg_rdata}, 38'd0);
    cpu_req = 1'b0;
    @(negedge qzt_clk);
    check("midrst_no_ack", {31'd0, cpu_ack}, 32'd0);
    reset = 1'b0;
    exp_cpu_rd = 8'h00;
    exp_dbg_rd = 8'h00;
    repeat (2) @(negedge qzt_clk);
    access(1'b1, 1'b1, 8'h40, 8'hC3);
    access(1'b0, 1'b0, 8'h40, 8'h00);

    repeat (4) @(negedge qzt_clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
